// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the program loader: FSM state encoding, header
//   magic and field positions, status codes and a byte-select helper used by
//   the tx serializer.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_INST = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_READBACK  = 3'd5,
        ST_SEND      = 3'd6,
        ST_FINISH    = 3'd7
    } state_t;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_HDR     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_INST_MSB  = 23;
    localparam int HDR_INST_LSB  = 12;
    localparam int HDR_DATA_MSB  = 11;
    localparam int HDR_DATA_LSB  = 0;

    // Word counters (k, j) and header counts share this width.
    localparam int CNT_W = 12;

    // Byte idx of a word, idx 0 = most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic hdr_ok(input logic [31:0] w);
        return (w[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == HDR_MAGIC) &&
               (w[HDR_INST_MSB:HDR_INST_LSB] != '0);
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler
//   Packs an inbound byte stream into 32-bit words, first byte in the MSB.
//   word_valid is a one-cycle pulse in the cycle after the 4th byte was
//   taken; word_out holds the completed word during that pulse.
// Ports:
//   clk, rst       clock, async active-high reset
//   clear          drop any partially assembled word
//   byte_en        byte_in is consumed this cycle
//   byte_in        inbound byte
//   word_out       assembled word
//   word_valid     completed-word pulse
//   byte_cnt       bytes already held for the word in progress (0..3)
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic [1:0]  byte_cnt
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (clear) begin
            cnt_d = 2'd0;
        end else if (byte_en) begin
            shift_d = {shift_q[23:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
            valid_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign word_out   = shift_q;
    assign word_valid = valid_q;
    assign byte_cnt   = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Loads a program image from a byte stream into processor_top's
//   instruction/data memories while the core is held in reset, runs the
//   core until done (or watchdog), then reads back the data words and sends
//   them out as bytes, MSB first.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | waiting for a header word
//   LOAD_INST  | writing instruction words k = 0..N-1
//   LOAD_DATA  | writing data words k = 0..M-1
//   SETTLE     | one cycle with outputs held before core release
//   RUN        | core running, watchdog counting
//   READBACK   | mem_addr = j driven, waiting READ_LAT cycles
//   SEND       | serializing the captured word, 4 bytes
//   FINISH     | core put back in reset, return to IDLE
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   rx_data/rx_valid/rx_ready         inbound byte handshake
//   tx_data/tx_valid/tx_ready         outbound byte handshake
//   core_rst                          reset to the core
//   inst_addr/inst_data_in            instruction memory write port
//   mem_addr/mem_data_in              data memory address / write data
//   processor_out                     data memory read data
//   done                              core halted
//   busy                              not in IDLE
//   err                               sticky status (ok / bad header / timeout)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 1_000_000,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        core_rst,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_data_in,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] processor_out,
    input  logic        done,
    output logic        busy,
    output logic [1:0]  err
);

    localparam int WD_W = $clog2(MAX_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(MAX_CYCLES - 1);
    localparam logic [3:0]      LAT_LAST = 4'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  m_q, m_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  j_q, j_d;
    logic [3:0]        lat_q, lat_d;
    logic [1:0]        b_q, b_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [31:0]       tx_word_q, tx_word_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rx_ready_q, rx_ready_d;
    logic              core_rst_q, core_rst_d;
    logic [1:0]        err_q, err_d;
    logic [CNT_W-1:0]  inst_addr_q, inst_addr_d;
    logic [31:0]       inst_data_q, inst_data_d;
    logic [CNT_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;

    logic        rx_accept;
    logic        asm_clear;
    logic [31:0] asm_word;
    logic        asm_valid;
    logic [1:0]  asm_cnt;
    logic        last_load_byte;
    logic        run_exit;

    assign rx_accept = rx_valid & rx_ready_q;
    assign asm_clear = (state_q == ST_FINISH);

    word_assembler u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_en    (rx_accept),
        .byte_in    (rx_data),
        .word_out   (asm_word),
        .word_valid (asm_valid),
        .byte_cnt   (asm_cnt)
    );

    // The final word of a load is written one cycle after its last byte is
    // taken; rx_ready drops for that gap so no stray byte is swallowed
    // while the FSM leaves the load phase.
    assign last_load_byte = rx_accept && (asm_cnt == 2'd3) &&
                            (((state_q == ST_LOAD_INST) && (k_q == n_q - 1'b1) && (m_q == '0)) ||
                             ((state_q == ST_LOAD_DATA) && (k_q == m_q - 1'b1)));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        m_d         = m_q;
        k_d         = k_q;
        j_d         = j_q;
        lat_d       = lat_q;
        b_d         = b_q;
        wd_d        = wd_q;
        tx_word_d   = tx_word_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        err_d       = err_q;
        inst_addr_d = inst_addr_q;
        inst_data_d = inst_data_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        run_exit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (asm_valid) begin
                    if (hdr_ok(asm_word)) begin
                        n_d     = asm_word[HDR_INST_MSB:HDR_INST_LSB];
                        m_d     = asm_word[HDR_DATA_MSB:HDR_DATA_LSB];
                        k_d     = '0;
                        err_d   = ERR_OK;
                        state_d = ST_LOAD_INST;
                    end else begin
                        err_d = ERR_HDR;
                    end
                end
            end
            ST_LOAD_INST: begin
                if (asm_valid) begin
                    inst_addr_d = k_q;
                    inst_data_d = asm_word;
                    if (k_q == n_q - 1'b1) begin
                        k_d     = '0;
                        state_d = (m_q != '0) ? ST_LOAD_DATA : ST_SETTLE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (asm_valid) begin
                    mem_addr_d = k_q;
                    mem_data_d = asm_word;
                    if (k_q == m_q - 1'b1) begin
                        k_d     = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                wd_d    = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                wd_d = wd_q + 1'b1;
                // done has priority over a watchdog expiring in the same cycle
                if (done) begin
                    run_exit = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    err_d    = ERR_TIMEOUT;
                    run_exit = 1'b1;
                end
                if (run_exit) begin
                    if (m_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        j_d        = '0;
                        mem_addr_d = '0;
                        lat_d      = '0;
                        state_d    = ST_READBACK;
                    end
                end
            end
            ST_READBACK: begin
                if (lat_q == LAT_LAST) begin
                    tx_word_d  = processor_out;
                    tx_data_d  = processor_out[31:24];
                    tx_valid_d = 1'b1;
                    b_d        = 2'd0;
                    state_d    = ST_SEND;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (b_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        if (j_q == m_q - 1'b1) begin
                            state_d = ST_FINISH;
                        end else begin
                            j_d        = j_q + 1'b1;
                            mem_addr_d = j_q + 1'b1;
                            lat_d      = '0;
                            state_d    = ST_READBACK;
                        end
                    end else begin
                        b_d       = b_q + 2'd1;
                        tx_data_d = word_byte(tx_word_q, b_q + 2'd1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rx_ready_d = ((state_d == ST_IDLE) || (state_d == ST_LOAD_INST) ||
                      (state_d == ST_LOAD_DATA)) && !last_load_byte;
        core_rst_d = !((state_d == ST_RUN) || (state_d == ST_READBACK) ||
                       (state_d == ST_SEND));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            m_q         <= '0;
            k_q         <= '0;
            j_q         <= '0;
            lat_q       <= '0;
            b_q         <= '0;
            wd_q        <= '0;
            tx_word_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            rx_ready_q  <= 1'b0;
            core_rst_q  <= 1'b1;
            err_q       <= ERR_OK;
            inst_addr_q <= '0;
            inst_data_q <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            m_q         <= m_d;
            k_q         <= k_d;
            j_q         <= j_d;
            lat_q       <= lat_d;
            b_q         <= b_d;
            wd_q        <= wd_d;
            tx_word_q   <= tx_word_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            rx_ready_q  <= rx_ready_d;
            core_rst_q  <= core_rst_d;
            err_q       <= err_d;
            inst_addr_q <= inst_addr_d;
            inst_data_q <= inst_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign core_rst     = core_rst_q;
    assign inst_addr    = {{(32-CNT_W){1'b0}}, inst_addr_q};
    assign inst_data_in = inst_data_q;
    assign mem_addr     = {{(32-CNT_W){1'b0}}, mem_addr_q};
    assign mem_data_in  = mem_data_q;
    assign busy         = (state_q != ST_IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int MAXC = 50;
    localparam int RL   = 2;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        core_rst;
    logic [31:0] inst_addr;
    logic [31:0] inst_data_in;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] processor_out;
    logic        done;
    logic        busy;
    logic [1:0]  err;

    prog_loader #(.MAX_CYCLES(MAXC), .READ_LAT(RL)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .core_rst      (core_rst),
        .inst_addr     (inst_addr),
        .inst_data_in  (inst_data_in),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .processor_out (processor_out),
        .done          (done),
        .busy          (busy),
        .err           (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // core model: one-cycle registered read of the result memory
    logic [31:0] res_mem [0:15];
    logic [31:0] rd_q;
    always @(posedge clk) rd_q <= res_mem[mem_addr[3:0]];
    assign processor_out = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // done model: dly>0 -> done after dly cycles of released core,
    // dly==0 -> done held high throughout, dly<0 -> never
    int done_dly = -1;
    int run_cyc  = 0;
    initial begin
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (done_dly == 0) begin
                done = 1'b1;
            end else if (core_rst) begin
                run_cyc = 0;
                done    = 1'b0;
            end else begin
                run_cyc++;
                if (done_dly > 0 && run_cyc >= done_dly) done = 1'b1;
            end
        end
    end

    bit tx_toggle = 1'b0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tx_toggle) tx_ready = ~tx_ready;
            else           tx_ready = 1'b1;
        end
    end

    // observation of load writes, tx bytes and event timing
    logic [31:0] ia_log[$], id_log[$], ma_log[$], md_log[$];
    logic [7:0]  tx_log[$];
    logic [63:0] prev_inst = '0, prev_mem = '0;
    logic        prev_crst = 1'b1, prev_txv = 1'b0;
    logic [1:0]  prev_err = 2'b00;
    int          last_load_cyc = -1, fall_cyc = -1, err2_cyc = -1, tx_first_cyc = -1;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (core_rst && {inst_addr, inst_data_in} != prev_inst) begin
                ia_log.push_back(inst_addr); id_log.push_back(inst_data_in);
                last_load_cyc = cyc;
            end
            if (core_rst && {mem_addr, mem_data_in} != prev_mem) begin
                ma_log.push_back(mem_addr); md_log.push_back(mem_data_in);
                last_load_cyc = cyc;
            end
            prev_inst = {inst_addr, inst_data_in};
            prev_mem  = {mem_addr, mem_data_in};
            if (prev_crst && !core_rst && fall_cyc < 0) fall_cyc = cyc;
            if (err == 2'b10 && prev_err != 2'b10 && err2_cyc < 0) err2_cyc = cyc;
            if (tx_valid && !prev_txv && tx_first_cyc < 0) tx_first_cyc = cyc;
            if (stall_prev && tx_valid) chk("tx_hold", {24'h0, tx_data}, {24'h0, stall_data});
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            prev_crst  = core_rst;
            prev_txv   = tx_valid;
            prev_err   = err;
        end
    end

    // caller is at a negedge; returns at the negedge after the accept edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            total++; bad++;
            $display("FAIL rx_accept_timeout: rx_ready got 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    typedef struct {
        logic [31:0] hdr;
        logic [1:0]  exp_err;
        logic        exp_busy;
    } hdr_vec_t;

    typedef struct {
        int         n;
        int         m;
        int         dly;
        logic [1:0] exp_err;
        bit         toggle;
    } run_vec_t;

    hdr_vec_t hv[3];
    run_vec_t rv[5];

    function automatic logic [31:0] inst_word(input int c, input int k);
        return 32'h1000_0000 | 32'(c << 8) | 32'(k);
    endfunction

    function automatic logic [31:0] data_word(input int c, input int k);
        if (c == 0) return (k == 0) ? 32'd19 : 32'd9;
        return 32'hD000_0000 | 32'(c << 8) | 32'(k);
    endfunction

    function automatic logic [31:0] res_word(input int c, input int j);
        if (c == 0) return (j == 0) ? 32'd9 : 32'd19;
        return 32'hA1B2_C300 | 32'(c << 4) | 32'(j);
    endfunction

    task automatic run_case(input int c);
        run_vec_t v;
        int n, exit_cyc;
        logic [31:0] w;
        v = rv[c];
        ia_log.delete(); id_log.delete(); ma_log.delete(); md_log.delete(); tx_log.delete();
        fall_cyc = -1; err2_cyc = -1; tx_first_cyc = -1; last_load_cyc = -1;
        done_dly  = v.dly;
        tx_toggle = v.toggle;
        for (int j = 0; j < 16; j++) res_mem[j] = res_word(c, j);

        send_word({8'hA5, 12'(v.n), 12'(v.m)});
        for (int k = 0; k < v.n; k++) begin
            w = inst_word(c, k);
            for (int i = 0; i < 4; i++) begin
                send_byte(w[31-8*i -: 8]);
                if (k == 0 && i == 0) chk($sformatf("c%0d err_cleared", c), {30'h0, err}, 32'h0);
            end
        end
        for (int k = 0; k < v.m; k++) send_word(data_word(c, k));
        rx_valid = 1'b0;

        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("c%0d finished", c), {31'h0, busy}, 32'h0);

        chk($sformatf("c%0d inst_cnt", c), 32'(ia_log.size()), 32'(v.n));
        for (int k = 0; k < v.n && k < ia_log.size(); k++) begin
            chk($sformatf("c%0d inst_addr%0d", c, k), ia_log[k], 32'(k));
            chk($sformatf("c%0d inst_data%0d", c, k), id_log[k], inst_word(c, k));
        end
        chk($sformatf("c%0d mem_cnt", c), 32'(ma_log.size()), 32'(v.m));
        for (int k = 0; k < v.m && k < ma_log.size(); k++) begin
            chk($sformatf("c%0d mem_addr%0d", c, k), ma_log[k], 32'(k));
            chk($sformatf("c%0d mem_data%0d", c, k), md_log[k], data_word(c, k));
        end
        chk($sformatf("c%0d core_rst_fall", c), 32'(fall_cyc - last_load_cyc), 32'd1);

        exit_cyc = (v.dly < 0) ? MAXC : ((v.dly == 0) ? 1 : v.dly);
        if (v.m > 0)
            chk($sformatf("c%0d first_tx_latency", c), 32'(tx_first_cyc - fall_cyc), 32'(exit_cyc + RL));
        if (v.exp_err == 2'b10)
            chk($sformatf("c%0d timeout_cycle", c), 32'(err2_cyc - fall_cyc), 32'(MAXC));

        chk($sformatf("c%0d tx_cnt", c), 32'(tx_log.size()), 32'(4 * v.m));
        for (int b = 0; b < 4 * v.m && b < tx_log.size(); b++) begin
            w = res_word(c, b / 4);
            chk($sformatf("c%0d tx_byte%0d", c, b), {24'h0, tx_log[b]}, {24'h0, w[31-8*(b%4) -: 8]});
        end
        chk($sformatf("c%0d err", c), {30'h0, err}, {30'h0, v.exp_err});
        chk($sformatf("c%0d core_rst_idle", c), {31'h0, core_rst}, 32'h1);
        chk($sformatf("c%0d rx_ready_idle", c), {31'h0, rx_ready}, 32'h1);
        tx_toggle = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " core_rst"}, {31'h0, core_rst}, 32'h1);
        chk({tag, " rx_ready"}, {31'h0, rx_ready}, 32'h0);
        chk({tag, " tx_valid"}, {31'h0, tx_valid}, 32'h0);
        chk({tag, " tx_data"}, {24'h0, tx_data}, 32'h0);
        chk({tag, " busy"}, {31'h0, busy}, 32'h0);
        chk({tag, " err"}, {30'h0, err}, 32'h0);
        chk({tag, " inst_addr"}, inst_addr, 32'h0);
        chk({tag, " inst_data_in"}, inst_data_in, 32'h0);
        chk({tag, " mem_addr"}, mem_addr, 32'h0);
        chk({tag, " mem_data_in"}, mem_data_in, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation got stuck expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        hv[0] = '{hdr: 32'h5A00_1001, exp_err: 2'b01, exp_busy: 1'b0};
        hv[1] = '{hdr: 32'hA500_0003, exp_err: 2'b01, exp_busy: 1'b0};
        hv[2] = '{hdr: 32'hFF12_3456, exp_err: 2'b01, exp_busy: 1'b0};

        rv[0] = '{n: 3, m: 2, dly: 20, exp_err: 2'b00, toggle: 1'b1};
        rv[1] = '{n: 1, m: 0, dly: 5,  exp_err: 2'b00, toggle: 1'b0};
        rv[2] = '{n: 2, m: 1, dly: -1, exp_err: 2'b10, toggle: 1'b0};
        rv[3] = '{n: 1, m: 3, dly: 0,  exp_err: 2'b00, toggle: 1'b1};
        rv[4] = '{n: 1, m: 1, dly: 50, exp_err: 2'b00, toggle: 1'b0};

        for (int j = 0; j < 16; j++) res_mem[j] = '0;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        repeat (3) @(negedge clk);
        chk_reset_values("por");
        rst = 1'b0;
        chk("rx_ready_before_edge", {31'h0, rx_ready}, 32'h0);
        @(negedge clk);
        chk("rx_ready_after_edge", {31'h0, rx_ready}, 32'h1);

        for (int i = 0; i < 3; i++) begin
            send_word(hv[i].hdr);
            rx_valid = 1'b0;
            repeat (3) @(negedge clk);
            chk($sformatf("hdr%0d err", i), {30'h0, err}, {30'h0, hv[i].exp_err});
            chk($sformatf("hdr%0d busy", i), {31'h0, busy}, {31'h0, hv[i].exp_busy});
        end

        for (int c = 0; c < 5; c++) run_case(c);

        // reset asserted two bytes into the data load
        send_word(32'hA500_1002);
        send_word(32'h7777_0001);
        send_byte(8'h12);
        send_byte(8'h34);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_values("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst rx_ready_before_edge", {31'h0, rx_ready}, 32'h0);
        @(negedge clk);
        chk("midrst rx_ready_after_edge", {31'h0, rx_ready}, 32'h1);
        run_case(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
